// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the codec PLL lock supervisor: state encoding,
// default timing parameters and a small helper for sizing the cycle counter.
// -----------------------------------------------------------------------------
package pll_sup_pkg;

   typedef logic [2:0] state_t;

   localparam state_t RESET_PLL = 3'd0;
   localparam state_t WAIT_LOCK = 3'd1;
   localparam state_t STABILIZE = 3'd2;
   localparam state_t RUNNING   = 3'd3;
   localparam state_t FAULT     = 3'd4;

   // Defaults for a 50 MHz reference clock
   localparam int DEF_RST_PULSE_CYCLES    = 16;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_MAX_RETRIES         = 3;

   // Width of a counter that must reach (largest of a, b, c) - 1; never zero.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for slow asynchronous status bits (e.g. PLL locked).
// Ports:
//   clk      - destination clock
//   reset_n  - synchronous active-low reset, clears both stages
//   d        - asynchronous input
//   q        - synchronized output, 2 cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Sequences the codec clock PLL: pulses its reset, waits for and qualifies
// lock, and only then releases clk_ready. Lock loss or lock timeout restarts
// the PLL; too many failed attempts park the block in FAULT until restart.
//
// Ports:
//   clk            - 50 MHz reference clock (same source as PLL refclk)
//   reset_n        - synchronous active-low reset
//   pll_locked     - PLL lock flag, asynchronous to clk
//   restart        - single-cycle re-init request (honoured in RUNNING/FAULT)
//   pll_rst        - active-high PLL reset
//   clk_ready      - PLL output clocks are valid
//   fault          - retries exhausted
//   retry_count    - failed attempts since last success or restart
//   lock_lost_cnt  - lock losses seen while RUNNING, saturates at 255
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RESET_PLL | pll_rst held high for RST_PULSE_CYCLES
// WAIT_LOCK | PLL released, waiting up to LOCK_TIMEOUT_CYCLES for lock
// STABILIZE | lock seen, must stay for LOCK_STABLE_CYCLES consecutive cycles
// RUNNING   | clk_ready high, watching for lock loss or restart
// FAULT     | retries exhausted, PLL held in reset until restart
// -----------------------------------------------------------------------------
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 pll_locked,
   input  logic                                 restart,
   output logic                                 pll_rst,
   output logic                                 clk_ready,
   output logic                                 fault,
   output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_count,
   output logic [7:0]                           lock_lost_cnt
);

   localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
   localparam int RW = $clog2(MAX_RETRIES+1);

   localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);

   logic           locked_s;
   state_t         state;
   state_t         state_nxt;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_nxt;
   logic [RW-1:0]  retry_nxt;
   logic [7:0]     lost_nxt;
   logic           attempt_failed;

   sync_2ff #(.WIDTH(1)) u_sync_locked (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pll_locked),
      .q       (locked_s)
   );

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt + CW'(1);
      retry_nxt      = retry_count;
      lost_nxt       = lock_lost_cnt;
      attempt_failed = 1'b0;

      case (state)
         RESET_PLL: begin
            if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s)                 state_nxt = STABILIZE;
            else if (cnt == TIMEOUT_LAST) attempt_failed = 1'b1;
         end
         STABILIZE: begin
            if (!locked_s) begin
               attempt_failed = 1'b1;
            end else if (cnt == STABLE_LAST) begin
               state_nxt = RUNNING;
               retry_nxt = '0;
            end
         end
         RUNNING: begin
            cnt_nxt = '0;
            // Lock loss takes priority over a simultaneous restart so the
            // event is never lost from the status counter.
            if (!locked_s) begin
               state_nxt = RESET_PLL;
               if (lock_lost_cnt != 8'hFF) lost_nxt = lock_lost_cnt + 8'd1;
            end else if (restart) begin
               state_nxt = RESET_PLL;
            end
         end
         FAULT: begin
            cnt_nxt = '0;
            if (restart) begin
               state_nxt = RESET_PLL;
               retry_nxt = '0;
            end
         end
         default: state_nxt = RESET_PLL;
      endcase

      if (attempt_failed) begin
         retry_nxt = retry_count + RW'(1);
         state_nxt = (retry_nxt == RW'(MAX_RETRIES)) ? FAULT : RESET_PLL;
      end

      // Every state entry starts its timer from zero.
      if (state_nxt != state) cnt_nxt = '0;
   end

   // Outputs are decoded from the next state so they change on the same
   // edge as the state itself.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= RESET_PLL;
         cnt           <= '0;
         pll_rst       <= 1'b1;
         clk_ready     <= 1'b0;
         fault         <= 1'b0;
         retry_count   <= '0;
         lock_lost_cnt <= '0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         pll_rst       <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
         clk_ready     <= (state_nxt == RUNNING);
         fault         <= (state_nxt == FAULT);
         retry_count   <= retry_nxt;
         lock_lost_cnt <= lost_nxt;
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

   localparam int RST = 4;
   localparam int TMO = 100;
   localparam int STB = 8;
   localparam int MR  = 3;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       restart = 1'b0;
   logic       pll_rst;
   logic       clk_ready;
   logic       fault;
   logic [1:0] retry_count;
   logic [7:0] lock_lost_cnt;

   always #10 clk = ~clk;

   pll_lock_supervisor #(
      .RST_PULSE_CYCLES    (RST),
      .LOCK_TIMEOUT_CYCLES (TMO),
      .LOCK_STABLE_CYCLES  (STB),
      .MAX_RETRIES         (MR)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pll_locked    (pll_locked),
      .restart       (restart),
      .pll_rst       (pll_rst),
      .clk_ready     (clk_ready),
      .fault         (fault),
      .retry_count   (retry_count),
      .lock_lost_cnt (lock_lost_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 0;
   bit ready_any = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Behavioural model: phase plus cycles-left-in-phase, lock seen through a
   // two-deep delay line.
   localparam int P_PULSE = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAULT = 4;
   int m_ph, m_left, m_tries, m_losses;
   bit m_d0, m_d1;

   task automatic model_failed_attempt();
      m_tries++;
      if (m_tries == MR) m_ph = P_FAULT;
      else begin
         m_ph = P_PULSE;
         m_left = RST;
      end
   endtask

   always @(posedge clk) begin
      bit seen;
      if (!reset_n) begin
         m_ph = P_PULSE; m_left = RST; m_tries = 0; m_losses = 0;
         m_d0 = 0; m_d1 = 0;
      end else begin
         seen = m_d1;
         m_d1 = m_d0;
         m_d0 = pll_locked;
         case (m_ph)
            P_PULSE: begin
               m_left--;
               if (m_left == 0) begin m_ph = P_WAIT; m_left = TMO; end
            end
            P_WAIT: begin
               if (seen) begin m_ph = P_STAB; m_left = STB; end
               else begin
                  m_left--;
                  if (m_left == 0) model_failed_attempt();
               end
            end
            P_STAB: begin
               if (!seen) model_failed_attempt();
               else begin
                  m_left--;
                  if (m_left == 0) begin m_ph = P_RUN; m_tries = 0; end
               end
            end
            P_RUN: begin
               if (!seen) begin
                  if (m_losses < 255) m_losses++;
                  m_ph = P_PULSE; m_left = RST;
               end else if (restart) begin
                  m_ph = P_PULSE; m_left = RST;
               end
            end
            default: begin
               if (restart) begin m_tries = 0; m_ph = P_PULSE; m_left = RST; end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("pll_rst",       pll_rst,       32'(m_ph == P_PULSE || m_ph == P_FAULT));
         chk("clk_ready",     clk_ready,     32'(m_ph == P_RUN));
         chk("fault",         fault,         32'(m_ph == P_FAULT));
         chk("retry_count",   retry_count,   m_tries);
         chk("lock_lost_cnt", lock_lost_cnt, m_losses);
      end
   end

   task automatic tick();
      @(negedge clk);
      if (clk_ready === 1'b1) ready_any = 1;
   endtask

   // Called at a negedge where pll_rst is high; counts samples until it drops.
   task automatic count_rst(output int n);
      n = 0;
      while (pll_rst === 1'b1 && n < 1000) begin
         n++;
         tick();
      end
   endtask

   task automatic wait_rst_rise();
      int k = 0;
      while (pll_rst !== 1'b1 && k < 300) begin k++; tick(); end
      chk("rst_rise_seen", pll_rst, 1);
   endtask

   task automatic wait_rst_fall();
      int k = 0;
      while (pll_rst !== 1'b0 && k < 300) begin k++; tick(); end
      chk("rst_fall_seen", pll_rst, 0);
   endtask

   // Edges from first high sample of pll_locked until clk_ready is seen.
   task automatic ready_latency(output int lat);
      int k = 0;
      do begin tick(); k++; end while (clk_ready !== 1'b1 && k < 500);
      lat = k - 1;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (clk_ready !== 1'b1 && k < 500) begin k++; tick(); end
      chk("ready_reached", clk_ready, 1);
   endtask

   task automatic wait_ready_fall(output int k);
      k = 0;
      do begin tick(); k++; end while (clk_ready !== 1'b0 && k < 50);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_pll_rst"},   pll_rst, 1);
      chk({tag, "_clk_ready"}, clk_ready, 0);
      chk({tag, "_fault"},     fault, 0);
      chk({tag, "_retry"},     retry_count, 0);
      chk({tag, "_lost"},      lock_lost_cnt, 0);
   endtask

   initial begin
      #(20 * 40000);
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, lat, k, f1, f2, f3, ff;

      repeat (3) tick();
      cmp_en = 1;
      chk_reset_outputs("reset");

      // 1: clean start, lock 20 cycles after pll_rst falls
      reset_n = 1;
      count_rst(n);
      chk("t1_rst_pulse_len", n, 4);
      repeat (20) tick();
      pll_locked = 1;
      ready_latency(lat);
      chk("t1_ready_latency", lat, 10);
      chk("t1_retry", retry_count, 0);

      // 2: no lock ever, from fresh reset
      pll_locked = 0;
      reset_n = 0;
      tick(); tick();
      reset_n = 1;
      f1 = -1; f2 = -1; f3 = -1; ff = -1;
      for (int j = 1; j <= 330; j++) begin
         tick();
         if (retry_count == 2'd1 && f1 < 0) f1 = j;
         if (retry_count == 2'd2 && f2 < 0) f2 = j;
         if (retry_count == 2'd3 && f3 < 0) f3 = j;
         if (fault === 1'b1 && ff < 0) ff = j;
      end
      chk("t2_retry1_at", f1, 104);
      chk("t2_retry2_at", f2, 208);
      chk("t2_retry3_at", f3, 312);
      chk("t2_fault_at",  ff, 312);
      repeat (200) tick();
      chk("t2_fault_held",   fault, 1);
      chk("t2_pll_rst_held", pll_rst, 1);

      // 3: restart out of FAULT, then lock
      restart = 1;
      tick();
      restart = 0;
      chk("t3_retry_cleared", retry_count, 0);
      chk("t3_fault_cleared", fault, 0);
      count_rst(n);
      chk("t3_rst_pulse_len", n, 4);
      pll_locked = 1;
      ready_latency(lat);
      chk("t3_ready_latency", lat, 10);

      // 4: restart from RUNNING, then 1-cycle lock glitch in STABILIZE
      restart = 1;
      tick();
      restart = 0;
      pll_locked = 0;
      chk("t4_restart_ready_low", clk_ready, 0);
      chk("t4_restart_no_loss", lock_lost_cnt, 0);
      wait_rst_fall();
      ready_any = 0;
      repeat (5) tick();
      pll_locked = 1;
      repeat (5) tick();
      pll_locked = 0;
      tick();
      pll_locked = 1;
      wait_rst_rise();
      count_rst(n);
      chk("t4_rst_pulse_len", n, 4);
      chk("t4_retry", retry_count, 1);
      chk("t4_ready_never", ready_any, 0);
      wait_ready();
      chk("t4_retry_after_lock", retry_count, 0);

      // 5: lock loss in RUNNING
      pll_locked = 0;
      wait_ready_fall(k);
      chk("t5_fall_within_3", 32'((k - 1) <= 3), 1);
      chk("t5_pll_rst_with_fall", pll_rst, 1);
      chk("t5_lost1", lock_lost_cnt, 1);
      chk("t5_retry", retry_count, 0);
      pll_locked = 1;
      wait_ready();
      // loss coinciding with restart
      pll_locked = 0;
      tick(); tick();
      restart = 1;
      tick();
      restart = 0;
      chk("t5_lost_with_restart", lock_lost_cnt, 2);
      pll_locked = 1;
      wait_ready();
      for (int i = 0; i < 298; i++) begin
         pll_locked = 0;
         wait_ready_fall(k);
         pll_locked = 1;
         wait_ready();
      end
      chk("t5_lost_300", lock_lost_cnt, 255);
      pll_locked = 0;
      wait_ready_fall(k);
      pll_locked = 1;
      wait_ready();
      chk("t5_lost_saturated", lock_lost_cnt, 255);

      // 6: reset mid-WAIT_LOCK, then mid-STABILIZE with a retry pending
      restart = 1;
      tick();
      restart = 0;
      pll_locked = 0;
      wait_rst_fall();
      repeat (10) tick();
      reset_n = 0;
      tick();
      chk_reset_outputs("t6_wait");
      reset_n = 1;
      count_rst(n);
      chk("t6_wait_rst_pulse_len", n, 4);
      k = 0;
      while (retry_count != 2'd1 && k < 300) begin k++; tick(); end
      chk("t6_pre_retry", retry_count, 1);
      wait_rst_fall();
      pll_locked = 1;
      repeat (5) tick();
      chk("t6_in_stab_not_ready", clk_ready, 0);
      reset_n = 0;
      tick();
      chk_reset_outputs("t6_stab");
      reset_n = 1;
      count_rst(n);
      chk("t6_stab_rst_pulse_len", n, 4);
      wait_ready();

      cmp_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
